iqueue_issue_reader: RTL

Consumer-side reader for the instruction queue's 4-wide issue bundle. It accepts whole 384-bit bundles (4 slots × {predicted target, PC, instruction}) under a valid/ready handshake and buffers them in a small bundle FIFO. It serializes the slots into a single-instruction stream for the decoder and flushes everything on a redirect. It sits between the instruction queue output and decode.

---
 rtl/iqueue_issue_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/iqueue_issue_reader.sv
// iqueue_issue_reader
//   Consumer-side reader for the instruction queue's 4-wide issue bundle.
//   Whole bundles are accepted under a valid/ready handshake into a small
//   bundle FIFO. The head bundle is then serialized, one slot at a time,
//   into a single-instruction stream for the decoder. A redirect (i_flush)
//   discards everything held.
//
//   Optional feature: define NOP_SKIP_EN to drop padding slots (== 96'h13)
//   so they never reach the decoder. When undefined, every slot is emitted.
//
// Parameters
//   SLOTS        slots per bundle; slot k occupies bits [96k+95:96k]
//   FIFO_DEPTH   bundle FIFO entries (power of two, >= 2)
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous, active-low reset
//   i_valid       bundle present on i_bundle
//   i_bundle      per slot: [31:0] instr, [63:32] PC, [95:64] predicted target
//   o_ready       FIFO can accept a bundle this cycle (registered)
//   i_flush       synchronous redirect, discards all held state
//   i_decReady    decoder accepts o_* this cycle
//   o_valid       instruction output valid
//   o_instr       instruction
//   o_pc          PC
//   o_predTarget  predicted target (0 = not predicted taken)
//   o_predTaken   o_predTarget != 0
//   o_slot        source slot index within the bundle
//   o_count       bundles held in the FIFO
module iqueue_issue_reader #(
    parameter int unsigned SLOTS      = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    input  logic [96*SLOTS-1:0]             i_bundle,
    output logic                            o_ready,
    input  logic                            i_flush,
    input  logic                            i_decReady,
    output logic                            o_valid,
    output logic [31:0]                     o_instr,
    output logic [31:0]                     o_pc,
    output logic [31:0]                     o_predTarget,
    output logic                            o_predTaken,
    output logic [$clog2(SLOTS)-1:0]        o_slot,
    output logic [$clog2(FIFO_DEPTH):0]     o_count
);

    localparam int unsigned SW = $clog2(SLOTS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Bundle storage
    // ------------------------------------------------------------------
    logic [96*SLOTS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [SW-1:0]       ptr;

    // ------------------------------------------------------------------
    // Head-bundle slot selection
    // ------------------------------------------------------------------
    logic [96*SLOTS-1:0] head;
    logic [SLOTS-1:0]    skip;
    logic                found;
    logic [SW-1:0]       sel;
    logic [95:0]         sel_slot;
    logic                more;

    logic                push;
    logic                advance;
    logic                load;
    logic                pop;
    logic [CW-1:0]       count_next;

    always_comb begin
        head     = mem[rd_ptr];
        skip     = '0;
        found    = 1'b0;
        sel      = '0;
        sel_slot = '0;
        more     = 1'b0;

        for (int unsigned k = 0; k < SLOTS; k++) begin
`ifdef NOP_SKIP_EN
            skip[k] = (head[96*k +: 96] == 96'h13);
`else
            skip[k] = 1'b0;
`endif
        end

        // Lowest non-skip slot at or after the current pointer.
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (!found && (SW'(k) >= ptr) && !skip[k]) begin
                found    = 1'b1;
                sel      = SW'(k);
                sel_slot = head[96*k +: 96];
            end
        end

        // Any further non-skip slot after the selected one. When none
        // remains, the head pops together with this load, so the pointer
        // never parks on an all-padding remainder.
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (found && (SW'(k) > sel) && !skip[k]) begin
                more = 1'b1;
            end
        end
    end

    always_comb begin
        push    = i_valid && o_ready && !i_flush;
        advance = (o_count != '0) && (!o_valid || i_decReady) && !i_flush;
        load    = advance && found;
        // A head with nothing left to emit pops without loading (one bubble).
        pop     = advance && (!found || !more);

        count_next = o_count;
        if (push && !pop) begin
            count_next = o_count + CW'(1);
        end else if (!push && pop) begin
            count_next = o_count - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO data (no reset needed; occupancy is tracked by o_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_bundle;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy, ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ptr     <= '0;
            o_count <= '0;
            o_ready <= 1'b1;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ptr     <= '0;
            o_count <= '0;
            o_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                ptr    <= '0;
            end else if (load) begin
                ptr    <= sel + SW'(1);
            end
            o_count <= count_next;
            o_ready <= (count_next != FULL);
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid      <= 1'b0;
            o_instr      <= '0;
            o_pc         <= '0;
            o_predTarget <= '0;
            o_predTaken  <= 1'b0;
            o_slot       <= '0;
        end else if (i_flush) begin
            o_valid      <= 1'b0;
            o_instr      <= '0;
            o_pc         <= '0;
            o_predTarget <= '0;
            o_predTaken  <= 1'b0;
            o_slot       <= '0;
        end else if (!o_valid || i_decReady) begin
            o_valid <= load;
            if (load) begin
                o_instr      <= sel_slot[31:0];
                o_pc         <= sel_slot[63:32];
                o_predTarget <= sel_slot[95:64];
                o_predTaken  <= (sel_slot[95:64] != '0);
                o_slot       <= sel;
            end
        end
    end

endmodule
